short_line_sched: RTL and testbench

SHORT_LINE_SCHED -- requirements
Module: short_line_sched

---
 rtl/g15_pkg.sv | 10 +
 rtl/short_line_timer.sv | 23 ++
 rtl/short_line_sched.sv | 89 ++++++++
 tb/tb_short_line_sched.sv | 137 +++++++++++++
 4 files changed

// File: rtl/g15_pkg.sv
// g15_pkg: shared drum geometry, short-line codes and scheduler states
package g15_pkg;
  localparam int BITS_PER_WORD = 29;
  localparam int SHORT_WORDS = 4;
  localparam logic [1:0] LINE_M20 = 2'd0;
  localparam logic [1:0] LINE_M21 = 2'd1;
  localparam logic [1:0] LINE_M22 = 2'd2;
  localparam logic [1:0] LINE_ILLEGAL = 2'd3;
  typedef enum logic [2:0] {IDLE, ARB, WAIT, XFER, FIN} state_t;
endpackage

// File: rtl/short_line_timer.sv
// short_line_timer: free-running drum position; T bit 0..BITS_PER_WORD-1, W word 0..SHORT_WORDS-1, eow high at the last bit of each word
module short_line_timer #(
  parameter int BITS_PER_WORD = g15_pkg::BITS_PER_WORD,
  parameter int SHORT_WORDS = g15_pkg::SHORT_WORDS,
  localparam int TW = $clog2(BITS_PER_WORD),
  localparam int WW = $clog2(SHORT_WORDS)
) (
  input  logic          CLOCK,
  input  logic          RST,
  output logic [TW-1:0] T,
  output logic [WW-1:0] W,
  output logic          eow
);
  assign eow = T == TW'(BITS_PER_WORD - 1);
  always_ff @(posedge CLOCK or posedge RST)
    if (RST) begin
      T <= '0;
      W <= '0;
    end else begin
      T <= eow ? '0 : T + 1'b1;
      if (eow) W <= W == WW'(SHORT_WORDS - 1) ? '0 : W + 1'b1;
    end
endmodule

// File: rtl/short_line_sched.sv
// short_line_sched: arbitrates two requesters for one word transfer into M20/M21/M22, timed to the drum position; REQ/LINE/WORD in, GNT/ERR/BUSY/DONE handshakes, TR/D5/DU/DV/DW registered transfer strobes, T/W position out
module short_line_sched #(
  parameter int BITS_PER_WORD = g15_pkg::BITS_PER_WORD,
  parameter int SHORT_WORDS = g15_pkg::SHORT_WORDS,
  localparam int TW = $clog2(BITS_PER_WORD),
  localparam int WW = $clog2(SHORT_WORDS)
) (
  input  logic          CLOCK,
  input  logic          RST,
  input  logic [1:0]    REQ,
  input  logic [1:0]    LINE0,
  input  logic [1:0]    LINE1,
  input  logic [WW-1:0] WORD0,
  input  logic [WW-1:0] WORD1,
  output logic [1:0]    GNT,
  output logic          DU,
  output logic          DV,
  output logic          DW,
  output logic          D5,
  output logic          TR,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [TW-1:0] T,
  output logic [WW-1:0] W
);
  import g15_pkg::*;
  state_t state, nxt;
  logic eow, any_req, win_one, illegal, arb, take, hit, prio;
  logic [1:0] sel_line, line_q;
  logic [WW-1:0] sel_word, word_q, w_next;
  short_line_timer #(.BITS_PER_WORD(BITS_PER_WORD), .SHORT_WORDS(SHORT_WORDS)) timer (
    .CLOCK(CLOCK),
    .RST(RST),
    .T(T),
    .W(W),
    .eow(eow)
  );
  // prio names the requester that wins the next tie
  always_comb begin
    any_req = |REQ;
    win_one = REQ[1] & (~REQ[0] | prio);
    sel_line = win_one ? LINE1 : LINE0;
    sel_word = win_one ? WORD1 : WORD0;
    illegal = sel_line == LINE_ILLEGAL;
    arb = state == ARB && any_req;
    take = arb && !illegal;
    w_next = W == WW'(SHORT_WORDS - 1) ? '0 : W + 1'b1;
    hit = eow && w_next == word_q;
    GNT = arb ? {win_one, !win_one} : 2'b00;
    ERR = arb && illegal;
    BUSY = state == WAIT || state == XFER || state == FIN || take;
    nxt = state;
    case (state)
      IDLE: nxt = any_req ? ARB : IDLE;
      ARB: nxt = take ? WAIT : IDLE;
      WAIT: nxt = hit ? XFER : WAIT;
      XFER: nxt = eow ? FIN : XFER;
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // strobes are decoded from the next state so they are clean flop outputs
  always_ff @(posedge CLOCK or posedge RST)
    if (RST) begin
      state <= IDLE;
      prio <= 1'b0;
      line_q <= LINE_M20;
      word_q <= '0;
      TR <= 1'b0;
      DU <= 1'b0;
      DV <= 1'b0;
      DW <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        line_q <= sel_line;
        word_q <= sel_word;
      end
      if (arb && &REQ) prio <= !win_one;
      TR <= nxt == XFER;
      DU <= nxt == XFER && line_q == LINE_M20;
      DV <= nxt == XFER && line_q == LINE_M21;
      DW <= nxt == XFER && line_q == LINE_M22;
      DONE <= nxt == FIN;
    end
  assign D5 = TR;
endmodule

// File: tb/tb_short_line_sched.sv
// tb_short_line_sched: directed and random stimulus checked against a transaction-level timing model
module tb_short_line_sched;
  logic CLOCK = 1'b0;
  logic RST = 1'b1;
  logic [1:0] REQ = '0, LINE0 = '0, LINE1 = '0, WORD0 = '0, WORD1 = '0;
  logic [1:0] GNT, W;
  logic DU, DV, DW, D5, TR, BUSY, DONE, ERR;
  logic [4:0] T;
  int checks = 0, failures = 0;
  int cyc, free_at, g_cyc, s_cyc, m_line;
  bit prio_m;
  logic [1:0] prev_req;
  always #5 CLOCK = ~CLOCK;
  short_line_sched dut (
    .CLOCK(CLOCK), .RST(RST), .REQ(REQ), .LINE0(LINE0), .LINE1(LINE1),
    .WORD0(WORD0), .WORD1(WORD1), .GNT(GNT), .DU(DU), .DV(DV), .DW(DW),
    .D5(D5), .TR(TR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .T(T), .W(W)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic model_reset;
    cyc = 0;
    free_at = 0;
    g_cyc = -1000;
    s_cyc = -1000;
    m_line = 0;
    prio_m = 1'b0;
    prev_req = 2'b00;
  endtask
  // free_at is the first cycle the scheduler is idle again; a transfer starts at
  // the first T=0 of the target word at least two cycles after the grant
  task automatic step(input logic [1:0] r, input logic [1:0] l0, input logic [1:0] l1,
                      input logic [1:0] w0, input logic [1:0] w1);
    logic [1:0] eg, ln, wd;
    logic ee, win;
    bit in_x;
    REQ = r; LINE0 = l0; LINE1 = l1; WORD0 = w0; WORD1 = w1;
    eg = 2'b00;
    ee = 1'b0;
    if (cyc - 1 >= free_at && prev_req != 2'b00) begin
      if (r == 2'b00) free_at = cyc + 1;
      else begin
        win = (r == 2'b11) ? prio_m : r[1];
        if (r == 2'b11) prio_m = !win;
        ln = win ? l1 : l0;
        wd = win ? w1 : w0;
        eg = win ? 2'b10 : 2'b01;
        if (ln == 2'd3) begin
          ee = 1'b1;
          free_at = cyc + 1;
        end else begin
          g_cyc = cyc;
          m_line = int'(ln);
          s_cyc = cyc + 2;
          while (s_cyc % 116 != int'(wd) * 29) s_cyc++;
          free_at = s_cyc + 30;
        end
      end
    end
    #1;
    in_x = cyc >= s_cyc && cyc <= s_cyc + 28;
    chk("T", T, cyc % 29);
    chk("W", W, (cyc / 29) % 4);
    chk("GNT", GNT, eg);
    chk("ERR", ERR, ee);
    chk("BUSY", BUSY, cyc >= g_cyc && cyc <= s_cyc + 29);
    chk("TR", TR, in_x);
    chk("D5", D5, in_x);
    chk("DONE", DONE, cyc == s_cyc + 29);
    chk("DSEL", {DU, DV, DW}, in_x ? 3'b100 >> m_line : 3'b000);
    @(posedge CLOCK);
    cyc++;
    prev_req = r;
    @(negedge CLOCK);
  endtask
  task automatic do_reset;
    RST = 1'b1;
    REQ = '0;
    @(negedge CLOCK);
    #1;
    chk("RST_T", T, 0);
    chk("RST_W", W, 0);
    chk("RST_OUT", {GNT, TR, D5, DU, DV, DW, BUSY, DONE, ERR}, 0);
    @(negedge CLOCK);
    RST = 1'b0;
    model_reset();
  endtask
  initial begin
    logic [1:0] r, l0, l1, w0, w1;
    model_reset();
    do_reset();
    for (int i = 0; i < 95; i++) step(i < 2 ? 2'b01 : 2'b00, 2'd1, 2'd0, 2'd2, 2'd0);
    do_reset();
    for (int i = 0; i < 420; i++) step(2'b11, 2'd0, 2'd2, 2'd1, 2'd3);
    do_reset();
    for (int i = 0; i < 240; i++) step((i == 91 || i == 92) ? 2'b01 : 2'b00, 2'd1, 2'd0, 2'd3, 2'd0);
    do_reset();
    for (int i = 0; i < 10; i++) step(i < 2 ? 2'b10 : 2'b00, 2'd0, 2'd3, 2'd0, 2'd1);
    do_reset();
    for (int i = 0; i < 70; i++) step(i < 2 ? 2'b01 : 2'b00, 2'd2, 2'd0, i < 2 ? 2'd1 : 2'd3, 2'd0);
    do_reset();
    while (cyc < 126) step(cyc < 2 ? 2'b01 : 2'b00, 2'd2, 2'd0, 2'd0, 2'd0);
    #1;
    chk("ABORT_PRE_TR", TR, 1);
    chk("ABORT_PRE_T", T, 10);
    #1 RST = 1'b1;
    #1;
    chk("ABORT_STROBES", {TR, D5, DU, DV, DW}, 0);
    chk("ABORT_BUSY", BUSY, 0);
    chk("ABORT_DONE", DONE, 0);
    chk("ABORT_T", T, 0);
    chk("ABORT_W", W, 0);
    @(negedge CLOCK);
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) step(2'b00, 2'd2, 2'd0, 2'd0, 2'd0);
    do_reset();
    r = 2'b00; l0 = 2'd0; l1 = 2'd0; w0 = 2'd0; w1 = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        l0 = 2'($urandom_range(0, 3));
        l1 = 2'($urandom_range(0, 3));
        w0 = 2'($urandom_range(0, 3));
        w1 = 2'($urandom_range(0, 3));
      end
      step(r, l0, l1, w0, w1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
